uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that sits directly downstream of the UART configuration register block. It accepts one byte at a time over a valid/ready handshake and drives an asynchronous serial frame on `tx`: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Parity mode and stop-bit count come from the configuration block's `paritybit` and `stopbit` outputs and are captured at the start of each frame.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range 2 to 65535.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-low (0 = reset).
- `tx_valid`  input  1  byte on `tx_data` is offered for transmission.
- `tx_data`  input  8  byte to send.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `paritybit`  input  2  from the config block: 00 = none, 01 = odd, 10 = even, 11 = none (reserved).
- `stopbit`  input  1  from the config block: 0 = one stop bit, 1 = two stop bits.
- `tx`  output  1  serial line; idles high (mark).
- `tx_done`  output  1  one-cycle pulse when a frame completes.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx` = 1, `tx_ready` = 1.
  - A transfer occurs on an edge where `tx_valid && tx_ready`. On that edge the block latches `tx_data`, `paritybit` and `stopbit` into internal registers and goes to START.
- START: `tx` = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - `tx` = latched data bit k, k = 0..7 (LSB first), each held CLKS_PER_BIT cycles.
  - After bit 7 the block goes to PARITY if latched parity is 01 or 10, otherwise to STOP.
- PARITY:
  - Even: `tx` = XOR of the 8 data bits.
  - Odd: `tx` = XNOR of the 8 data bits.
  - Held CLKS_PER_BIT cycles, then STOP.
- STOP: `tx` = 1 for CLKS_PER_BIT cycles (one stop bit) or 2×CLKS_PER_BIT cycles (two stop bits), then IDLE with `tx_done` = 1 for that one cycle.
- Changes to `paritybit`, `stopbit` or `tx_data` during a frame have no effect until the next transfer.
- `tx_valid` while `tx_ready` = 0 is ignored. No data is queued.
- Bit-period counter: ceil(log2(CLKS_PER_BIT)) bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Bit index: 3 bits.
- All outputs are registered.

## Timing

- Reset values (`rst` = 0 at an edge): state IDLE, `tx` = 1, `tx_ready` = 1, `tx_done` = 0, all counters 0.
- Reset is honoured mid-frame. The frame is aborted at that edge, with no partial completion and no `tx_done`.
- Transfer at edge N:
  - `tx` = 0 and `tx_ready` = 0 are visible from edge N onward.
  - Frame length L = (1 + 8 + P + S) × CLKS_PER_BIT cycles, with P = 1 if parity is enabled else 0, and S = 1 or 2.
  - At edge N+L: `tx` = 1 (idle), `tx_ready` = 1, `tx_done` = 1. `tx_done` returns to 0 at edge N+L+1.
- Back-to-back frames: a transfer can occur at edge N+L+1 at the earliest. There is therefore exactly one clock of idle mark between consecutive frames.
- Latency from handshake to the start-bit falling edge on `tx`: 0 cycles, i.e. the same edge as the handshake.

## Test plan

All scenarios use CLKS_PER_BIT = 4.

1. **Reset mid-frame.** Hold `rst` = 0 for 2 edges, then release. Send 0xA5 and assert `rst` = 0 during DATA bit 3.
   - `tx` = 1 and `tx_ready` = 1 throughout reset and on the next edge after the mid-frame reset.
   - No `tx_done` for the aborted frame.
2. **No parity, 1 stop.** `paritybit` = 00, `stopbit` = 0, send 0xA5.
   - `tx` sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. L = 40.
   - `tx_done` pulses at handshake + 40.
3. **Even parity, 1 stop.** `paritybit` = 10, `stopbit` = 0, send 0x07.
   - Parity bit = 1. L = 44.
   - Repeat with `paritybit` = 01: parity bit = 0.
4. **Odd parity, 2 stops.** `paritybit` = 01, `stopbit` = 1, send 0x00.
   - Parity bit = 1. Stop high for 8 cycles. L = 48.
   - Change `paritybit` to 00 mid-frame: the frame is unaffected.
5. **Back-to-back frames with busy-time valid.** Hold `tx_valid` = 1 continuously with 0x55, then 0x3C.
   - Second start bit begins exactly 1 cycle after the first `tx_done`.
   - Pulses of `tx_valid` while `tx_ready` = 0 are not accepted.
6. **Reserved parity code.** `paritybit` = 11, send 0xFF.
   - Frame behaves as no parity. L = 40.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx : 8-bit async serial transmitter, optional parity, 1/2 stop bits |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic [1:0] paritybit,
    input  logic       stopbit,
    output logic       tx,
    output logic       tx_done
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               par_en_q, par_en_d;
    logic               par_odd_q, par_odd_d;
    logic               two_stop_q, two_stop_d;
    logic               stop2_q, stop2_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               w_bit_end;

    assign w_bit_end = (cnt_q == c_CNT_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = w_bit_end ? '0 : cnt_q + c_CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_d      = 3'd0;
                    stop2_d    = 1'b0;
                    data_d     = tx_data;
                    // Code 11 is reserved and treated as no parity.
                    par_en_d   = paritybit[0] ^ paritybit[1];
                    par_odd_d  = (paritybit == 2'b01);
                    two_stop_d = stopbit;
                end
            end
            S_START: begin
                if (w_bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they register on the same edge.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = par_odd_d ? ~^data_d : ^data_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            data_q     <= 8'd0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx : directed bench for uart_tx with CLKS_PER_BIT = 4            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_uart_tx;

    localparam int c_CPB = 4;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [1:0] paritybit;
    logic       stopbit;
    logic       tx;
    logic       tx_done;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .paritybit (paritybit),
        .stopbit   (stopbit),
        .tx        (tx),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},    32'(tx),       32'd1);
        chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_done"},  32'(tx_done),  32'd0);
    endtask

    // Drive a handshake; returns at 1 time unit after the transfer edge.
    task automatic xfer(input logic [7:0] d, input logic [1:0] p, input logic s, input logic hold);
        tx_valid  = 1'b1;
        tx_data   = d;
        paritybit = p;
        stopbit   = s;
        tick();
        if (!hold) tx_valid = 1'b0;
    endtask

    // pat holds the expected bit periods, first-sent bit in pat[nbits-1].
    task automatic run_frame(input string tag, input logic [11:0] pat, input int nbits);
        int cyc;
        logic eb;
        cyc = 0;
        for (int b = 0; b < nbits; b++) begin
            eb = pat[nbits-1-b];
            for (int c = 0; c < c_CPB; c++) begin
                chk({tag, "_tx"},    32'(tx),       32'(eb));
                chk({tag, "_busy"},  32'(tx_ready), 32'd0);
                chk({tag, "_nodone"},32'(tx_done),  32'd0);
                tick();
                cyc++;
            end
        end
        chk({tag, "_len"},       32'(cyc),      32'(nbits * c_CPB));
        chk({tag, "_end_tx"},    32'(tx),       32'd1);
        chk({tag, "_end_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_end_done"},  32'(tx_done),  32'd1);
    endtask

    initial begin
        int ndone;
        rst       = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        paritybit = 2'b00;
        stopbit   = 1'b0;

        // 1. Reset, then abort a frame during data bit 3.
        tick();
        chk_idle("rst0");
        tick();
        chk_idle("rst1");
        rst = 1'b1;
        tick();
        chk_idle("post_rst");

        xfer(8'hA5, 2'b00, 1'b0, 1'b0);
        chk("abort_start_tx", 32'(tx), 32'd0);
        chk("abort_start_ready", 32'(tx_ready), 32'd0);
        repeat (17) tick();
        chk("abort_bit3_tx", 32'(tx), 32'd0);
        chk("abort_bit3_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk_idle("abort_rst");
        rst = 1'b1;
        tick();
        chk_idle("abort_after");
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_done === 1'b1 || tx !== 1'b1) ndone++;
            tick();
        end
        chk("abort_quiet", 32'(ndone), 32'd0);

        // 2. No parity, one stop, 0xA5.
        xfer(8'hA5, 2'b00, 1'b0, 1'b0);
        run_frame("np1", 12'b0101001011, 10);
        tick();
        chk("np1_done_clear", 32'(tx_done), 32'd0);
        chk_idle("np1_idle");

        // 3. Even then odd parity, one stop, 0x07.
        xfer(8'h07, 2'b10, 1'b0, 1'b0);
        run_frame("even", 12'b01110000011, 11);
        tick();
        chk_idle("even_idle");
        xfer(8'h07, 2'b01, 1'b0, 1'b0);
        run_frame("odd", 12'b01110000001, 11);
        tick();
        chk_idle("odd_idle");

        // 4. Odd parity, two stops, 0x00; config and data change mid-frame.
        xfer(8'h00, 2'b01, 1'b1, 1'b0);
        fork
            run_frame("odd2", 12'b000000000111, 12);
            begin
                repeat (10) tick();
                paritybit = 2'b00;
                stopbit   = 1'b0;
                tx_data   = 8'hFF;
            end
        join
        tick();
        chk_idle("odd2_idle");

        // 5. tx_valid held high: back-to-back frames, busy-time valid ignored.
        xfer(8'h55, 2'b00, 1'b0, 1'b1);
        fork
            run_frame("b2b_a", 12'b0101010101, 10);
            begin
                repeat (6) tick();
                tx_data = 8'h3C;
            end
        join
        tick();
        chk("b2b_gap_tx", 32'(tx), 32'd0);
        chk("b2b_gap_ready", 32'(tx_ready), 32'd0);
        chk("b2b_gap_done", 32'(tx_done), 32'd0);
        tx_valid = 1'b0;
        run_frame("b2b_b", 12'b0001111001, 10);
        tick();
        chk_idle("b2b_idle");

        // 6. Reserved parity code behaves as none.
        xfer(8'hFF, 2'b11, 1'b0, 1'b0);
        run_frame("rsvd", 12'b0111111111, 10);
        tick();
        chk_idle("rsvd_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
